uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_ctrl_fifo.sv | 48 ++++
 rtl/uart_tx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit controller.
// Register indices, STATUS bit positions, FSM encoding, divisor width.
package uart_pkg;

  localparam int DIV_W = 16;
  localparam int CNT_W = 7;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int SB_BUSY  = 0;
  localparam int SB_FULL  = 1;
  localparam int SB_EMPTY = 2;
  localparam int SB_OVF   = 3;
  localparam int SB_CNT   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// Synchronous FIFO with fall-through read port.
// A push while full is taken only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clkout,
  input  logic             ext_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clkout) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
// uart_tx is a registered copy of the FSM line level.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clkout,
  input  logic        ext_reset,
  input  logic        wen,
  input  logic        ren,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_RST =
    DIV_W'(CLK_FREQ / BAUD);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_AFTER = S_PARITY;
`else
  localparam logic [2:0] S_AFTER = S_STOP;
`endif

  logic [2:0]       state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] timer;
  logic [7:0]       shreg;
  logic [2:0]       bitcnt;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_q;
  logic [CW-1:0]    fifo_cnt;
  logic             line_d;
  logic [31:0]      status;
  logic [31:0]      rd_mux;
  logic             unused_hi;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  assign unused_hi = ^data_in[31:16];
  assign push = wen && address == REG_TXDATA;
  assign pop  = !fifo_empty &&
    (state == S_IDLE ||
     (state == S_STOP && timer == '0));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkout    (clkout),
    .ext_reset (ext_reset),
    .push      (push),
    .pop       (pop),
    .wdata     (data_in[7:0]),
    .rdata     (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      state   <= S_IDLE;
      div_cur <= DIV_RST;
      timer   <= '0;
      shreg   <= '0;
      bitcnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (pop) begin
      state   <= S_START;
      div_cur <= div;
      timer   <= div - DIV_W'(1);
      shreg   <= fifo_q;
      bitcnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= ^fifo_q;
`endif
    end else if (state != S_IDLE) begin
      if (timer != '0) begin
        timer <= timer - DIV_W'(1);
      end else begin
        timer <= div_cur - DIV_W'(1);
        case (state)
          S_START: state <= S_DATA;
          S_DATA: begin
            shreg  <= {1'b0, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_AFTER;
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: state <= S_STOP;
`endif
          // STOP with nothing queued
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    line_d = 1'b1;
    case (state)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = par;
`else
      S_PARITY: line_d = 1'b1;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_comb begin
    status = '0;
    status[SB_BUSY]  = state != S_IDLE;
    status[SB_FULL]  = fifo_full;
    status[SB_EMPTY] = fifo_empty;
    status[SB_OVF]   = ovf;
    status[SB_CNT +: CNT_W] = CNT_W'(fifo_cnt);
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      address == REG_STATUS:  rd_mux = status;
      address == REG_BAUDDIV: rd_mux = {16'h0, div};
      address == REG_TXDATA,
      address == REG_RSVD:    rd_mux = '0;
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      div      <= DIV_RST;
      ovf      <= 1'b0;
      data_out <= '0;
      uart_tx  <= 1'b1;
      tx_irq   <= 1'b1;
    end else begin
      if (wen && address == REG_BAUDDIV)
        div <= (data_in[15:0] < 16'd2) ?
               16'd2 : data_in[15:0];
      // a racing overflow wins over the read-clear
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (ren && address == REG_STATUS)
        ovf <= 1'b0;
      if (ren) data_out <= rd_mux;
      uart_tx <= line_d;
      tx_irq  <= fifo_empty && state == S_IDLE;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl.
// Frame-level reference model; line, IRQ and read data checked per cycle.
module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clkout = 1'b0;
  logic        ext_reset;
  logic        wen;
  logic        ren;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        uart_tx;
  logic        tx_irq;

  int n_chk = 0;
  int n_pass = 0;

  uart_tx_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clkout    (clkout),
    .ext_reset (ext_reset),
    .wen       (wen),
    .ren       (ren),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .uart_tx   (uart_tx),
    .tx_irq    (tx_irq)
  );

  always #5 clkout = ~clkout;

  // reference model state
  int          e;
  logic [7:0]  q[$];
  int          div_m;
  bit          ovf_m;
  int          cur_end;
  int          fs[$];
  int          fd[$];
  logic [7:0]  fb[$];
  bit          exp_line;
  bit          exp_irq;
  bit          idle_prev;
  bit          irq_stable;
  bit          rd_pend;
  logic [31:0] rd_exp;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
  endtask

  function automatic bit bitval(input logic [7:0] b,
                                input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FL == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete(); fs.delete(); fd.delete(); fb.delete();
    div_m = CLK_FREQ / BAUD;
    ovf_m = 0;
    cur_end = 0;
    idle_prev = 1;
    rd_exp = 0;
    rd_pend = 0;
  endtask

  task automatic model_edge();
    bit busy;
    bit idle_now;
    e++;
    busy = e <= cur_end;
    idle_now = !busy && q.size() == 0;
    irq_stable = idle_now == idle_prev;
    exp_irq = idle_now;
    idle_prev = idle_now;
    if (ren) begin
      rd_pend = 1;
      case (address)
        2'd1: rd_exp = (q.size() << 4) | (int'(ovf_m) << 3)
                     | (int'(q.size() == 0) << 2)
                     | (int'(q.size() == DEPTH) << 1)
                     | int'(busy);
        2'd2: rd_exp = div_m;
        default: rd_exp = 0;
      endcase
      if (address == 2'd1) ovf_m = 0;
    end
    if (q.size() > 0 && e >= cur_end) begin
      fs.push_back(e + 1);
      fd.push_back(div_m);
      fb.push_back(q.pop_front());
      cur_end = e + FL * div_m;
    end
    if (wen && address == 2'd0) begin
      if (q.size() < DEPTH) q.push_back(data_in[7:0]);
      else ovf_m = 1;
    end
    if (wen && address == 2'd2)
      div_m = (data_in[15:0] < 2) ? 2 : int'(data_in[15:0]);
    while (fs.size() > 1 && fs[1] <= e) begin
      void'(fs.pop_front());
      void'(fd.pop_front());
      void'(fb.pop_front());
    end
    exp_line = 1'b1;
    if (fs.size() > 0 && fs[0] <= e &&
        e < fs[0] + FL * fd[0])
      exp_line = bitval(fb[0], (e - fs[0]) / fd[0]);
  endtask

  task automatic tick();
    @(posedge clkout);
    model_edge();
    @(negedge clkout);
    chk("uart_tx", {31'b0, uart_tx}, {31'b0, exp_line});
    if (irq_stable)
      chk("tx_irq", {31'b0, tx_irq}, {31'b0, exp_irq});
    if (rd_pend) begin
      chk("rdata", data_out, rd_exp);
      rd_pend = 0;
    end else begin
      chk("rhold", data_out, rd_exp);
    end
    wen = 0;
    ren = 0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    wen = 1; address = a; data_in = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a);
    ren = 1; address = a;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ext_reset = 0;
    wen = 0; ren = 0; address = 0; data_in = 0;
    e = 0;
    model_reset();
    repeat (3) @(negedge clkout);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_irq", {31'b0, tx_irq}, 32'd1);
    chk("rst_dout", data_out, 32'd0);
    ext_reset = 1;
    rd(2'd2);
    rd(2'd1);

    // basic frame, back-to-back frames
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h55);
    idle(50);
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h3C);
    idle(90);

    // overflow while a frame is in flight
    wr(2'd0, 32'h11);
    idle(5);
    for (int i = 0; i < 17; i++) wr(2'd0, $urandom);
    rd(2'd1);
    idle(3);
    rd(2'd1);
    idle(17 * 40 + 20);

    // divisor clamp
    wr(2'd2, 32'd1);
    rd(2'd2);
    wr(2'd0, 32'hFF);
    idle(30);
    wr(2'd2, 32'hABCD_0000);
    rd(2'd2);

    // divisor change mid-frame
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h5A);
    wr(2'd0, 32'hC3);
    idle(10);
    wr(2'd2, 32'd8);
    idle(40 + 80 + 20);

    // reserved slot and TXDATA reads
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    rd(2'd0);
    rd(2'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 3) begin
        wen = 1; address = 2'd0; data_in = $urandom;
      end else if (op == 3) begin
        wen = 1; address = 2'd2;
        data_in = {16'($urandom), 16'($urandom_range(0, 5))};
      end else if (op == 4) begin
        ren = 1; address = 2'($urandom_range(0, 3));
      end else if (op == 5) begin
        wen = 1; ren = 1;
        address = 2'($urandom_range(0, 3));
        data_in = $urandom_range(0, 300);
      end
      tick();
    end
    idle(1000);
    rd(2'd1);

`ifdef UART_TX_PARITY_EN
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h07);
    idle(50);
`endif

    // async reset in the middle of the data bits
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h00);
    idle(12);
    chk("pre_rst_tx", {31'b0, uart_tx}, 32'd0);
    #2 ext_reset = 0;
    #1 chk("async_tx", {31'b0, uart_tx}, 32'd1);
    model_reset();
    repeat (3) @(negedge clkout);
    ext_reset = 1;
    rd(2'd1);
    rd(2'd2);
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
